// File: rtl/tx_fifo_scheduler.sv
// tx_fifo_scheduler: round-robin merge of two byte sources into a TX FIFO,
// and a read-side FSM that pops the FIFO head and launches a UART frame.
// Optional per-source accepted-byte counters: define TX_SCHED_STATS_EN.
module tx_fifo_scheduler #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s0_valid,
  input  logic [DW-1:0] s0_data,
  output logic          s0_ready,
  input  logic          s1_valid,
  input  logic [DW-1:0] s1_data,
  output logic          s1_ready,
  output logic          fifo_wr,
  output logic [DW-1:0] fifo_wdata,
  input  logic          fifo_full,
  output logic          fifo_rd,
  input  logic [DW-1:0] fifo_rdata,
  input  logic          fifo_empty,
  output logic          tx_start,
  output logic [DW-1:0] tx_data,
  input  logic          tx_busy
`ifdef TX_SCHED_STATS_EN
  ,
  output logic [15:0]   cnt0,
  output logic [15:0]   cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          last_grant_q, last_grant_d;  // 1: source 1 was granted last
  logic [DW-1:0] tx_data_q, tx_data_d;
  logic          grant0, grant1;
  logic          pop;

  // Write-side arbiter: at most one grant, only when the FIFO has room
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!fifo_full) begin
      if (s0_valid && s1_valid) begin
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end else if (s0_valid) begin
        grant0 = 1'b1;
      end else if (s1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  // Write-side outputs and last-grant update
  always_comb begin
    s0_ready     = grant0;
    s1_ready     = grant1;
    fifo_wr      = grant0 | grant1;
    fifo_wdata   = '0;
    last_grant_d = last_grant_q;
    if (grant0) begin
      fifo_wdata   = s0_data;
      last_grant_d = 1'b0;
    end else if (grant1) begin
      fifo_wdata   = s1_data;
      last_grant_d = 1'b1;
    end
  end

  // Registers; reset leaves source 0 winning the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      tx_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      tx_data_q    <= tx_data_d;
    end
  end

  // Read-side next state: pop, launch, then follow the busy handshake
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!fifo_empty && !tx_busy) state_d = START;
      START:   state_d = WAIT_HI;
      WAIT_HI: if (tx_busy) state_d = WAIT_LO;
      WAIT_LO: if (!tx_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read-side outputs; the pop is held off while reset is asserted
  always_comb begin
    pop       = (state_q == IDLE) && !fifo_empty && !tx_busy && !rst;
    fifo_rd   = pop;
    tx_start  = (state_q == START);
    tx_data   = tx_data_q;
    tx_data_d = pop ? fifo_rdata : tx_data_q;
  end

`ifdef TX_SCHED_STATS_EN
  logic [15:0] cnt0_q, cnt0_d;
  logic [15:0] cnt1_q, cnt1_d;

  // Saturating accepted-byte counters
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (grant0 && (cnt0_q != 16'hFFFF)) cnt0_d = cnt0_q + 16'd1;
    if (grant1 && (cnt1_q != 16'hFFFF)) cnt1_d = cnt1_q + 16'd1;
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: doc/tx_fifo_scheduler.md
TX_FIFO_SCHEDULER -- requirements
Module: tx_fifo_scheduler

Interface
REQ-001 SHALL have parameter DW, default 8, data byte width; only 8 is supported.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports s0_valid/s1_valid  input  1  source byte offered.
REQ-005 SHALL have ports s0_data/s1_data  input  8  source byte.
REQ-006 SHALL have ports s0_ready/s1_ready  output  1  byte accepted this cycle.
REQ-007 SHALL have ports fifo_wr  output  1, fifo_wdata  output  8: FIFO push port.
REQ-008 SHALL have port fifo_full  input  1  FIFO cannot accept a push.
REQ-009 SHALL have ports fifo_rd  output  1, fifo_rdata  input  8 (combinational head), fifo_empty  input  1: FIFO pop port.
REQ-010 SHALL have ports tx_start  output  1, tx_data  output  8: UART transmitter launch.
REQ-011 SHALL have port tx_busy  input  1  UART transmitter frame in progress.

Function
REQ-012 SHALL arbitrate write side combinationally: a grant is issued only when fifo_full=0 and at least one sN_valid=1; at most one grant per cycle.
REQ-013 SHALL resolve both-valid cycles round-robin: the source not granted last wins; the last-grant register updates only on a grant.
REQ-014 SHALL drive sN_ready=1 exactly for the granted source, fifo_wr=1 on any grant, fifo_wdata=granted sN_data; otherwise fifo_wr=0, fifo_wdata=0.
REQ-015 SHALL never assert sN_ready while fifo_full=1.
REQ-016 SHALL implement read-side FSM states IDLE, START, WAIT_HI, WAIT_LO.
REQ-017 IDLE: when fifo_empty=0 and tx_busy=0, SHALL assert fifo_rd=1 that cycle, capture fifo_rdata into tx_data at the edge, go to START; else stay.
REQ-018 START: SHALL assert tx_start=1 for exactly one cycle, then go to WAIT_HI.
REQ-019 WAIT_HI: SHALL stay until tx_busy=1, then go to WAIT_LO.
REQ-020 WAIT_LO: SHALL stay until tx_busy=0, then go to IDLE.
REQ-021 SHALL assert fifo_rd only in IDLE and never when fifo_empty=1.
REQ-022 SHALL hold tx_data stable from capture until the next capture.
REQ-023 SHALL allow a write-side push and a read-side pop in the same cycle, each independent of the other.
REQ-024 Latency: tx_start SHALL rise one cycle after the IDLE cycle observing fifo_empty=0 and tx_busy=0.

Reset
REQ-025 On rst=1, asynchronously: FSM=IDLE, tx_start=0, tx_data=0, fifo_rd=0, last-grant=source 1 (source 0 wins first tie).
REQ-026 Reset mid-frame SHALL abandon the frame; no further tx_start until the IDLE conditions hold after release.
REQ-027 Write-side outputs SHALL follow REQ-012..014 combinationally during and after reset.

Configuration
REQ-028 With macro TX_SCHED_STATS_EN defined, SHALL add outputs cnt0, cnt1 (16 bits each): accepted-byte counters per source, saturating at 0xFFFF, cleared by rst.
REQ-029 Without TX_SCHED_STATS_EN, cnt0/cnt1 and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 Single source: s0 sends 0x55 into empty FIFO, tx_busy low -> fifo_wr with 0x55, then one fifo_rd, tx_start pulse, tx_data=0x55.
REQ-031 Contention: s0 and s1 hold valid (0xA0.., 0xB0..) for 4 cycles after reset -> grants s0,s1,s0,s1; FIFO order A0,B0,A1,B1.
REQ-032 Full: fifo_full=1 with both valid -> s0_ready=s1_ready=fifo_wr=0 until full drops.
REQ-033 Busy handshake: tx_busy held high 20 cycles after tx_start -> no fifo_rd, no second tx_start until tx_busy falls; next byte launched afterwards.
REQ-034 Reset in WAIT_LO with 3 bytes queued -> tx_start=0 immediately, tx_data=0; after release, next pop occurs on first IDLE cycle with tx_busy=0.
REQ-035 With TX_SCHED_STATS_EN: 5 bytes from s0, 3 from s1 -> cnt0=5, cnt1=3; rst -> both 0.
